logarithm: RTL

Iterative fixed-point natural-logarithm unit; it is the inverse companion of the `exponential` block. It accepts a 2.16 unsigned operand in the same `{intpart, fracpart}` format that `exponential` produces. It returns ln(y) as a 0.16 fraction on a start/done handshake. The datapath uses multiplicative normalization (shift-and-add against a ln(1+2^-k) table), so the block needs no multiplier, and round-trip tests chain it directly after `exponential`.

---
 rtl/logarithm_pkg.sv | 26 ++
 rtl/log_lut.sv | 17 +
 rtl/logarithm.sv | 115 +++++++++++
 3 files changed

// File: rtl/logarithm_pkg.sv
// rtl/logarithm_pkg.sv - shared widths, state encoding and ln(1+2^-k) table for the log unit
package logarithm_pkg;

    localparam int ITER = 17;
    localparam int GW   = 4;
    localparam int YW   = 22;
    localparam int AW   = 21;
    localparam int KW   = 5;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_FIN  = 2'd2;

    localparam logic [YW-1:0] P_ONE = 22'h10_0000;

    // round(ln(1+2^-k) * 2^20) for k = 0..16
    localparam logic [AW-1:0] LN_TABLE [ITER] = '{
        21'hB1721, 21'h67CC9, 21'h391FF, 21'h1E270,
        21'h0F852, 21'h07E0A, 21'h03F81, 21'h01FE0,
        21'h00FF8, 21'h007FE, 21'h00400, 21'h00200,
        21'h00100, 21'h00080, 21'h00040, 21'h00020,
        21'h00010
    };

endpackage

// File: rtl/log_lut.sv
// rtl/log_lut.sv - combinational ROM from iteration index to ln(1+2^-k) in 1.20 format
module log_lut
    import logarithm_pkg::*;
(
    input  logic [KW-1:0] i_k,
    output logic [AW-1:0] o_ln
);

    // Indices past the last iteration read as zero so the finalize cycle adds nothing.
    always_comb begin
        o_ln = '0;
        if (i_k < KW'(ITER)) begin
            o_ln = LN_TABLE[i_k];
        end
    end

endmodule

// File: rtl/logarithm.sv
// rtl/logarithm.sv - iterative ln(y) for 2.16 operands via multiplicative normalization
module logarithm
    import logarithm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  intpart,
    input  logic [15:0] fracpart,
    output logic        done,
    output logic [15:0] lnx,
    output logic        ovf,
    output logic        err
);

    state_t          r_state;
    state_t          w_next;
    logic [KW-1:0]   r_k;
    logic [YW-1:0]   r_y;
    logic [YW-1:0]   r_p;
    logic [AW-1:0]   r_acc;
    logic [YW:0]     w_t;
    logic            w_take;
    logic [AW-1:0]   w_lk;
    logic [17:0]     w_r;
    logic            w_err_cond;
    logic            w_load;
    logic            w_step;
    logic            w_finish;

    log_lut u_lut (
        .i_k  (r_k),
        .o_ln (w_lk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // CALC runs k = 0..ITER-1 as iterations and k = ITER as the finalize cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_FIN: if (start) w_next = ST_CALC;
            ST_CALC:         if (r_k == KW'(ITER)) w_next = ST_FIN;
            default:         w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            ST_IDLE, ST_FIN: w_load = start;
            ST_CALC: begin
                if (r_k == KW'(ITER)) w_finish = 1'b1;
                else                  w_step   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        if (r_k == '0) w_t = {r_p, 1'b0};
        else           w_t = {1'b0, r_p} + {1'b0, (r_p >> r_k)};
    end

    assign w_take     = (w_t <= {1'b0, r_y});
    assign w_r        = {1'b0, r_acc[AW-1:4]} + {17'd0, r_acc[3]};
    assign w_err_cond = (r_y[YW-1:YW-2] == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k   <= '0;
            r_y   <= '0;
            r_p   <= '0;
            r_acc <= '0;
            done  <= 1'b0;
            lnx   <= '0;
            ovf   <= 1'b0;
            err   <= 1'b0;
        end else if (w_load) begin
            r_k   <= '0;
            r_y   <= {intpart, fracpart, {GW{1'b0}}};
            r_p   <= P_ONE;
            r_acc <= '0;
            done  <= 1'b0;
            ovf   <= 1'b0;
            err   <= 1'b0;
        end else if (w_step) begin
            if (w_take) begin
                r_p   <= w_t[YW-1:0];
                r_acc <= r_acc + w_lk;
            end
            r_k <= r_k + KW'(1);
        end else if (w_finish) begin
            done <= 1'b1;
            if (w_err_cond) begin
                lnx <= '0;
                err <= 1'b1;
            end else if (w_r >= 18'h10000) begin
                lnx <= 16'hFFFF;
                ovf <= 1'b1;
            end else begin
                lnx <= w_r[15:0];
            end
        end
    end

endmodule
